// File: rtl/isqrt_fsm.sv
// Iterative unsigned integer square root: one operand in flight, one root bit per cycle.
// Restoring digit recurrence over an n-bit radicand producing an n/2-bit floor(sqrt(x)).
module isqrt_fsm #(
    parameter int n = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           x_vld,
    input  logic [n-1:0]   x,
    output logic           x_rdy,
    output logic           y_vld,
    output logic [n/2-1:0] y
);

    localparam int H  = n / 2;
    localparam int CW = $clog2(H + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state;
    logic [n-1:0]  opnd;
    logic [H-1:0]  root;
    logic [H+1:0]  rem;
    logic [CW-1:0] cnt;

    logic [H+1:0]  rem_sh;
    logic [H+2:0]  trial;
    logic [H:0]    root_sh;
    logic [H-1:0]  root_nxt;
    logic [H+1:0]  rem_nxt;

    // One recurrence step; trial is one bit wider than the remainder so its MSB is a clean sign.
    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        rem_sh   = {rem[H-1:0], opnd[n-1 -: 2]};
        trial    = {1'b0, rem_sh} - {1'b0, root, 2'b01};
        root_sh  = {root, ~trial[H+2]};
        root_nxt = root_sh[H-1:0];
        rem_nxt  = trial[H+2] ? rem_sh : trial[H+1:0];
    end

    assign x_rdy = (state == IDLE);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opnd  <= '0;
            root  <= '0;
            rem   <= '0;
            cnt   <= '0;
            y     <= '0;
            y_vld <= 1'b0;
        end else begin
            y_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (x_vld) begin
                        opnd  <= x;
                        root  <= '0;
                        rem   <= '0;
                        cnt   <= CW'(H);
                        state <= CALC;
                    end
                end
                CALC: begin
                    opnd <= opnd << 2;
                    root <= root_nxt;
                    rem  <= rem_nxt;
                    cnt  <= cnt - CW'(1);
                    // Last iteration: publish the completed root directly into y.
                    if (cnt == CW'(1)) begin
                        y     <= root_nxt;
                        y_vld <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_fsm.sv
// Directed and reference-model checks for isqrt_fsm at n=32.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_isqrt_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_vld;
    logic [31:0] x;
    logic        x_rdy;
    logic        y_vld;
    logic [15:0] y;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;
    int acc_q[$];
    logic [15:0] last_y;

    isqrt_fsm #(.n(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .x_vld(x_vld),
        .x    (x),
        .x_rdy(x_rdy),
        .y_vld(y_vld),
        .y    (y)
    );

    always #5 clk = ~clk;

    // Record the cycle index of every accepting edge and count result pulses.
    always @(posedge clk) begin
        cyc++;
        if (!rst && x_vld && x_rdy) acc_q.push_back(cyc);
    end
    always @(negedge clk) if (y_vld) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent floor-sqrt by binary search on 64-bit squares.
    function automatic logic [15:0] isqrt_ref(input logic [31:0] v);
        longint lo = 0;
        longint hi = 65535;
        longint mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(v)) lo = mid;
            else hi = mid - 1;
        end
        return lo[15:0];
    endfunction

    // Called at a falling edge with the block idle; returns at the falling edge after DONE.
    task automatic run_op(input logic [31:0] val, input logic [15:0] exp, input string tag);
        int lat;
        int p0;
        p0 = pulses;
        check({tag, "_rdy"}, 32'(x_rdy), 32'd1);
        x     = val;
        x_vld = 1'b1;
        @(negedge clk);
        x_vld = 1'b0;
        x     = $urandom;
        check({tag, "_busy"}, 32'(x_rdy), 32'd0);
        lat = 0;
        while (!y_vld && lat < 40) begin
            check({tag, "_hold"}, 32'(y), 32'(last_y));
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, 16);
        check({tag, "_y"}, 32'(y), 32'(exp));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(y_vld), 32'd0);
        check({tag, "_keep"}, 32'(y), 32'(exp));
        check({tag, "_npulse"}, pulses - p0, 1);
        last_y = exp;
    endtask

    initial begin
        int n_acc;
        int p0;
        int t;
        logic [31:0] r;
        logic [31:0] sq;

        rst    = 1'b1;
        x_vld  = 1'b1;
        x      = 32'd49;
        last_y = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(x_rdy), 32'd1);
        check("rst_vld", 32'(y_vld), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_noacc", acc_q.size(), 0);
        rst   = 1'b0;
        x_vld = 1'b0;

        // Basic values from idle.
        run_op(32'd0, 16'd0, "x0");
        run_op(32'd1, 16'd1, "x1");
        run_op(32'd15, 16'd3, "x15");
        run_op(32'd16, 16'd4, "x16");
        run_op(32'd17, 16'd4, "x17");
        run_op(32'hFFFF_FFFF, 16'd65535, "xmax");

        // Back-to-back with x_vld held high: second acceptance 18 cycles after the first.
        n_acc = acc_q.size();
        p0    = pulses;
        x     = 32'd144;
        x_vld = 1'b1;
        @(negedge clk);
        x = 32'd1_000_000;
        t = 0;
        while (!y_vld && t < 40) begin @(negedge clk); t++; end
        check("b2b_y1", 32'(y), 32'd12);
        t = 0;
        while (acc_q.size() < n_acc + 2 && t < 40) begin
            check("b2b_stable", 32'(y), 32'd12);
            @(negedge clk);
            t++;
        end
        x_vld = 1'b0;
        check("b2b_nacc", acc_q.size(), n_acc + 2);
        if (acc_q.size() >= n_acc + 2)
            check("b2b_gap", acc_q[n_acc+1] - acc_q[n_acc], 18);
        t = 0;
        while (!y_vld && t < 40) begin
            check("b2b_stable2", 32'(y), 32'd12);
            @(negedge clk);
            t++;
        end
        check("b2b_y2", 32'(y), 32'd1000);
        @(negedge clk);
        check("b2b_pulses", pulses - p0, 2);
        last_y = 16'd1000;

        // Busy input: x=4 presented during CALC is taken only once the block is idle.
        n_acc = acc_q.size();
        p0    = pulses;
        x     = 32'd81;
        x_vld = 1'b1;
        @(negedge clk);
        x = 32'd4;
        t = 0;
        while (!y_vld && t < 40) begin @(negedge clk); t++; end
        check("busy_y1", 32'(y), 32'd9);
        check("busy_nacc1", acc_q.size(), n_acc + 1);
        t = 0;
        while (acc_q.size() < n_acc + 2 && t < 40) begin @(negedge clk); t++; end
        x_vld = 1'b0;
        t = 0;
        while (!y_vld && t < 40) begin @(negedge clk); t++; end
        check("busy_y2", 32'(y), 32'd2);
        @(negedge clk);
        check("busy_pulses", pulses - p0, 2);
        check("busy_nacc2", acc_q.size(), n_acc + 2);
        last_y = 16'd2;

        // Reset at CALC iteration 5 aborts without a result pulse.
        p0    = pulses;
        x     = 32'd625;
        x_vld = 1'b1;
        @(negedge clk);
        x_vld = 1'b0;
        repeat (5) @(negedge clk);
        rst   = 1'b1;
        x_vld = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        x_vld = 1'b0;
        check("abort_rdy", 32'(x_rdy), 32'd1);
        check("abort_y", 32'(y), 32'd0);
        check("abort_vld", 32'(y_vld), 32'd0);
        repeat (20) @(negedge clk);
        check("abort_nopulse", pulses - p0, 0);
        last_y = 16'd0;
        run_op(32'd625, 16'd25, "after_abort");

        // Regression: perfect squares and their predecessors on a stride, then random operands.
        for (int k = 1; k <= 65535; k += 257) begin
            sq = 32'(k) * 32'(k);
            run_op(sq, 16'(k), "sq");
            run_op(sq - 32'd1, 16'(k - 1), "sqm1");
        end
        run_op(32'hFFFE_0001, 16'd65535, "sq_top");
        run_op(32'hFFFE_0000, 16'd65534, "sqm1_top");
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            run_op(r, isqrt_ref(r), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
